// File: rtl/miriscv_lsu_pkg.sv
// Shared types and constants for the load/store unit: access size codes,
// FSM state encoding and the byte-enable helper.
package miriscv_lsu_pkg;

    localparam int MEM_ACCESS_W = 3;

    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_WORD  = 3'd0;
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_HALF  = 3'd1;
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_BYTE  = 3'd2;
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UHALF = 3'd3;
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UBYTE = 3'd4;

    localparam int MEM_BE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } lsu_state_t;

    // Offset must already be aligned for the access size.
    function automatic logic [MEM_BE_W-1:0] lsu_byte_en(
        input logic [MEM_ACCESS_W-1:0] size,
        input logic [1:0]              offset
    );
        case (size)
            MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: lsu_byte_en = 4'b0001 << offset;
            MEM_ACCESS_HALF, MEM_ACCESS_UHALF: lsu_byte_en = 4'b0011 << offset;
            default:                           lsu_byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/miriscv_lsu_load_ext.sv
// Load data aligner: picks the byte/half at the access offset and extends it.
// Latency: combinational. Backpressure: none.
// Flow: pure function of (size, offset, rdata).
module miriscv_lsu_load_ext
    import miriscv_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [MEM_ACCESS_W-1:0] size_i,
    input  logic [1:0]              offset_i,
    input  logic [XLEN-1:0]         rdata_i,
    output logic [XLEN-1:0]         data_o
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        case (size_i)
            MEM_ACCESS_BYTE:  data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            MEM_ACCESS_UBYTE: data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            MEM_ACCESS_HALF:  data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            MEM_ACCESS_UHALF: data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default:          data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: one execute-stage access -> req/gnt/rvalid data port, extended load data back.
// Latency: 3 cycles minimum (capture, request with same-cycle grant, response).
// Backpressure: stalls the pipeline until rvalid; request held stable until gnt. MIRISCV_LSU_MISALIGN_TRAP_EN traps illegal accesses.
module miriscv_lsu
    import miriscv_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BE_W = XLEN / 8
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [MEM_ACCESS_W-1:0] lsu_size_i,
    input  logic [XLEN-1:0]         lsu_addr_i,
    input  logic [XLEN-1:0]         lsu_wdata_i,
    output logic                    lsu_stall_req_o,
    output logic                    lsu_done_o,
    output logic [XLEN-1:0]         lsu_rdata_o,
    output logic                    lsu_misalign_o,
    output logic                    data_req_o,
    output logic                    data_we_o,
    output logic [BE_W-1:0]         data_be_o,
    output logic [XLEN-1:0]         data_addr_o,
    output logic [XLEN-1:0]         data_wdata_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic [XLEN-1:0]         data_rdata_i
);

    lsu_state_t              state;
    logic                    we_q;
    logic [MEM_ACCESS_W-1:0] size_q;
    logic [1:0]              off_q;
    logic [XLEN-1:0]         addr_q;
    logic [BE_W-1:0]         be_q;
    logic [XLEN-1:0]         wdata_q;

    logic                    idle_req;
    logic                    trap;
    logic                    accept;
    logic [MEM_ACCESS_W-1:0] eff_size;
    logic [1:0]              eff_off;
    logic [XLEN-1:0]         eff_wdata;
    logic [XLEN-1:0]         ext_rdata;

    assign idle_req = (state == IDLE) & lsu_req_i;

`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
    logic illegal;

    always_comb begin
        case (lsu_size_i)
            MEM_ACCESS_WORD:  illegal = (lsu_addr_i[1:0] != 2'b00);
            MEM_ACCESS_HALF:  illegal = lsu_addr_i[0];
            MEM_ACCESS_UHALF: illegal = lsu_addr_i[0] | lsu_we_i;
            MEM_ACCESS_BYTE:  illegal = 1'b0;
            MEM_ACCESS_UBYTE: illegal = lsu_we_i;
            default:          illegal = 1'b1;
        endcase
    end

    assign trap = idle_req & illegal;
`else
    assign trap = 1'b0;
`endif

    assign accept         = idle_req & ~trap;
    assign lsu_misalign_o = trap;

    // Without the trap, illegal requests are coerced into a legal shape here.
    always_comb begin
        eff_size = lsu_size_i;
        eff_off  = lsu_addr_i[1:0];
        case (lsu_size_i)
            MEM_ACCESS_HALF:  eff_off = {lsu_addr_i[1], 1'b0};
            MEM_ACCESS_UHALF: begin
                eff_off = {lsu_addr_i[1], 1'b0};
                if (lsu_we_i) eff_size = MEM_ACCESS_HALF;
            end
            MEM_ACCESS_BYTE:  eff_off = lsu_addr_i[1:0];
            MEM_ACCESS_UBYTE: if (lsu_we_i) eff_size = MEM_ACCESS_BYTE;
            default: begin
                eff_size = MEM_ACCESS_WORD;
                eff_off  = 2'b00;
            end
        endcase
    end

    always_comb begin
        case (eff_size)
            MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: eff_wdata = {4{lsu_wdata_i[7:0]}};
            MEM_ACCESS_HALF, MEM_ACCESS_UHALF: eff_wdata = {2{lsu_wdata_i[15:0]}};
            default:                           eff_wdata = lsu_wdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= MEM_ACCESS_WORD;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state   <= REQ;
                    we_q    <= lsu_we_i;
                    size_q  <= eff_size;
                    off_q   <= eff_off;
                    addr_q  <= {lsu_addr_i[XLEN-1:2], 2'b00};
                    be_q    <= lsu_byte_en(eff_size, eff_off);
                    wdata_q <= eff_wdata;
                end
                REQ:     if (data_gnt_i) state <= RESP;
                RESP:    if (data_rvalid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    miriscv_lsu_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .size_i   (size_q),
        .offset_i (off_q),
        .rdata_i  (data_rdata_i),
        .data_o   (ext_rdata)
    );

    assign data_req_o   = (state == REQ);
    assign data_we_o    = data_req_o & we_q;
    assign data_be_o    = data_req_o ? be_q : '0;
    assign data_addr_o  = data_req_o ? addr_q : '0;
    assign data_wdata_o = data_req_o ? wdata_q : '0;

    assign lsu_done_o      = (state == RESP) & data_rvalid_i;
    assign lsu_rdata_o     = (lsu_done_o & ~we_q) ? ext_rdata : '0;
    assign lsu_stall_req_o = accept | data_req_o | ((state == RESP) & ~data_rvalid_i);

endmodule

// File: doc/miriscv_lsu.md
Name: miriscv_lsu

Overview:
- Load/store unit between the execute stage and the data-memory port.
- Takes one access per instruction, encoded with the MEM_ACCESS_* size codes. Drives a req/gnt/rvalid memory interface with byte enables and replicated store data.
- Returns aligned, sign- or zero-extended load data and stalls the pipeline until the access completes.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.
- BE_W, XLEN/8, byte-enable width.

Ports:
- clk_i  in  1  core clock
- arstn_i  in  1  asynchronous active-low reset
- lsu_req_i  in  1  execute stage requests a memory access
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_size_i  in  MEM_ACCESS_W  access size code (MEM_ACCESS_*)
- lsu_addr_i  in  XLEN  byte address
- lsu_wdata_i  in  XLEN  store data, right-aligned
- lsu_stall_req_o  out  1  hold the pipeline
- lsu_done_o  out  1  access completes this cycle
- lsu_rdata_o  out  XLEN  extended load data, valid with lsu_done_o on a load
- lsu_misalign_o  out  1  misaligned or illegal access detected (see Optional Feature)
- data_req_o  out  1  memory request
- data_we_o  out  1  memory write
- data_be_o  out  BE_W  byte enables
- data_addr_o  out  XLEN  word-aligned address
- data_wdata_o  out  XLEN  replicated store data
- data_gnt_i  in  1  request accepted
- data_rvalid_i  in  1  response valid; returned for both loads and stores
- data_rdata_i  in  XLEN  read data

Behaviour:
- FSM states: IDLE, REQ, RESP. Reset puts the FSM in IDLE and clears all capture registers. Every output is 0 during and after reset.
- IDLE:
  - If lsu_req_i is high and the access is legal: capture we, size, addr[1:0], the word address, byte enables and wdata; go to REQ.
  - lsu_stall_req_o = lsu_req_i in IDLE (combinational), so the instruction is held.
- REQ:
  - data_req_o = 1; data_we_o, data_be_o, data_addr_o and data_wdata_o come only from the capture registers.
  - The request is held stable until data_gnt_i. On grant go to RESP. The request is never retracted.
  - lsu_stall_req_o = 1.
- RESP:
  - lsu_stall_req_o = 1 until data_rvalid_i.
  - In the cycle data_rvalid_i = 1: lsu_stall_req_o = 0, lsu_done_o = 1, lsu_rdata_o = extended data_rdata_i (combinational; 0 on stores). Go to IDLE.
- Minimum latency: 3 cycles (IDLE capture, REQ with same-cycle gnt, RESP with rvalid).
- Back-to-back: the core advances in the done cycle, so a new lsu_req_i seen in IDLE the next cycle starts a new access.
- Byte enables:
  - BYTE/UBYTE: 4'b0001 << addr[1:0].
  - HALF/UHALF: 4'b0011 << {addr[1],1'b0}.
  - WORD: 4'b1111.
- Store data: byte replicated x4, half replicated x2, word unchanged.
- data_addr_o = {addr[XLEN-1:2], 2'b00}.
- Load extraction: select byte/half by the registered offset. Sign-extend for BYTE/HALF, zero-extend for UBYTE/UHALF. WORD passes through.
- Illegal/misaligned conditions: WORD with addr[1:0] != 0; HALF/UHALF with addr[0] = 1; size code 5, 6 or 7; UHALF/UBYTE with we = 1.
- data_gnt_i outside REQ and data_rvalid_i outside RESP are ignored; this covers stale responses after a mid-operation reset.
- Reset mid-operation aborts immediately. No done pulse is produced.

Optional Feature:
- Macro: MIRISCV_LSU_MISALIGN_TRAP_EN.
- Defined:
  - An illegal or misaligned request in IDLE pulses lsu_misalign_o for one cycle.
  - No memory request is issued, lsu_stall_req_o = 0 and lsu_done_o = 0; the core takes the trap.
- Undefined:
  - lsu_misalign_o is tied to 0.
  - Misaligned addresses have their low bits forced to alignment for the given size.
  - Size codes 5, 6 and 7 are treated as WORD; unsigned stores are treated as signed stores.

Decomposition:
- Add to miriscv_lsu_pkg:
  - lsu_state_t enum (IDLE/REQ/RESP).
  - MEM_BE_W constant.
  - Existing MEM_ACCESS_* codes reused unchanged.
- Sub-module miriscv_lsu_load_ext: combinational byte/half select and sign/zero extension from (size, offset, rdata).

Test Plan:
- LW addr 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF:
  - data_be_o = 4'hF, data_addr_o = 0x100, done on cycle 3, lsu_rdata_o = 0xDEADBEEF.
- LB addr 0x103 and LBU addr 0x103 with rdata 0x80FF_0000:
  - data_be_o = 4'b1000; lsu_rdata_o = 0xFFFFFF80 for LB, 0x00000080 for LBU.
- SH addr 0x206, wdata 0x1234ABCD, gnt delayed 3 cycles:
  - data_be_o = 4'b1100, data_wdata_o = 0xABCDABCD held stable for all 4 REQ cycles, stall held until rvalid.
- LW addr 0x101:
  - With macro: lsu_misalign_o = 1 for 1 cycle and data_req_o stays 0.
  - Without macro: data_addr_o = 0x100.
- arstn_i low during RESP, then a spurious data_rvalid_i after release:
  - FSM in IDLE, lsu_done_o and lsu_stall_req_o stay 0.
